reg_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard detector. Register-indexed scoreboard that counts in-flight writes per architectural register and replaces the per-stage rd compare chain.
- Sits beside ID. It stalls ID on RAW hazards, on optional WAW hazards, and on per-register counter saturation.
- Supports NRET simultaneous writeback/retire ports, optional same-cycle writeback bypass, and pipeline flush.

---
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 95 +++++++++
 tb/tb_reg_scoreboard.sv | 131 +++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID/retire handshake bundle between the pipeline and the register scoreboard.
// master drives flush, ID operand fields, ex_ready and the retire ports, and observes the results.
// slave (the scoreboard) drives id_stall, issue, busy_vec, inflight and err.
interface reg_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int CNT_W = 2,
    parameter int NRET  = 2
);
    localparam int RW = $clog2(NREGS);
    logic                  flush;
    logic                  id_valid;
    logic [RW-1:0]         id_rs1;
    logic                  id_en_rs1;
    logic [RW-1:0]         id_rs2;
    logic                  id_en_rs2;
    logic [RW-1:0]         id_rd;
    logic                  id_en_rd;
    logic                  ex_ready;
    logic [NRET-1:0]       ret_valid;
    logic [NRET*RW-1:0]    ret_rd;
    logic                  id_stall;
    logic                  issue;
    logic [NREGS-1:0]      busy_vec;
    logic [CNT_W+RW-1:0]   inflight;
    logic                  err;
    modport master (
        output flush, id_valid, id_rs1, id_en_rs1, id_rs2, id_en_rs2, id_rd, id_en_rd,
               ex_ready, ret_valid, ret_rd,
        input  id_stall, issue, busy_vec, inflight, err
    );
    modport slave (
        input  flush, id_valid, id_rs1, id_en_rs1, id_rs2, id_en_rs2, id_rd, id_en_rd,
               ex_ready, ret_valid, ret_rd,
        output id_stall, issue, busy_vec, inflight, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that stall ID on RAW/WAW/saturation hazards.
// clk, reset: clock and synchronous active-high reset.
// bus (slave): ID operands, ex_ready, flush and NRET retire ports in; id_stall, issue,
// registered busy_vec, inflight (sum of all counters) and sticky underflow err out.
module reg_scoreboard #(
    parameter int NREGS     = 32,
    parameter int CNT_W     = 2,
    parameter int NRET      = 2,
    parameter int CHECK_WAW = 1,
    parameter int WB_BYPASS = 1
) (
    input logic            clk,
    input logic            reset,
    reg_scoreboard_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int IW = CNT_W + RW;
    localparam int NR = 1 << RW;
    localparam int DW = $clog2(NRET + 1);
    localparam int XW = (CNT_W > DW ? CNT_W : DW) + 2;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [XW-1:0]    dec [NREGS];
    logic [XW-1:0]    sum;
    // Sized to the full index space so any RW-bit index is in range; spare entries stay 0.
    logic [NR-1:0]    hz;
    logic [NR-1:0]    sat_v;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             raw, waw, sat, stall, iss;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec[r] = '0;
            for (int k = 0; k < NRET; k++)
                if (r != 0 && bus.ret_valid[k] && bus.ret_rd[k*RW +: RW] == RW'(r))
                    dec[r] = dec[r] + XW'(1);
        end
    end

    // hz[r]: register r still has an outstanding write as seen by ID this cycle.
    always_comb begin
        hz = '0;
        sat_v = '0;
        for (int r = 1; r < NREGS; r++) begin
            hz[r] = WB_BYPASS != 0 ? XW'(cnt_q[r]) > dec[r] : cnt_q[r] != '0;
            sat_v[r] = cnt_q[r] == CMAX && dec[r] == '0;
        end
    end

    assign raw   = (bus.id_en_rs1 && hz[bus.id_rs1]) || (bus.id_en_rs2 && hz[bus.id_rs2]);
    assign waw   = CHECK_WAW != 0 && bus.id_en_rd && hz[bus.id_rd];
    assign sat   = bus.id_en_rd && sat_v[bus.id_rd];
    assign stall = bus.id_valid && (bus.flush || raw || waw || sat);
    assign iss   = bus.id_valid && bus.ex_ready && !stall;

    // Retires that would drive a counter negative clamp it to 0 and latch err; flush wipes
    // everything and suppresses the retires it overrides.
    always_comb begin
        err_d = err_q;
        busy_d = '0;
        inflight_d = '0;
        sum = '0;
        for (int r = 0; r < NREGS; r++) begin
            sum = XW'(cnt_q[r]) + XW'(iss && bus.id_en_rd && r != 0 && bus.id_rd == RW'(r));
            cnt_d[r] = (bus.flush || sum < dec[r]) ? '0 : CNT_W'(sum - dec[r]);
            err_d = err_d | (!bus.flush && sum < dec[r]);
            busy_d[r] = cnt_d[r] != '0;
            inflight_d = inflight_d + IW'(cnt_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '{default: '0};
            busy_q <= '0;
            inflight_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            inflight_q <= inflight_d;
            err_q <= err_d;
        end
    end

    assign bus.id_stall = stall;
    assign bus.issue    = iss;
    assign bus.busy_vec = busy_q;
    assign bus.inflight = inflight_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scoreboard bench for reg_scoreboard (default and no-WAW/no-bypass builds).
module tb_reg_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0, r = 1'b1, fl = 1'b0, v = 1'b0;
    logic       e1 = 1'b0, e2 = 1'b0, erd = 1'b0, exr = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic [1:0] rv = '0;
    logic [9:0] rrd = '0;
    logic       rst_a, rst_b;
    logic       o_stall, o_issue, o_err;
    logic [31:0] o_busy;
    logic [6:0] o_infl;
    int checks = 0, fails = 0;

    string      tq[$];
    logic [31:0] bq[$];
    logic [6:0] nq[$];
    logic       eq[$];

    // The idle build is held in reset so each phase starts from a clean scoreboard.
    assign rst_a = sel ? 1'b1 : r;
    assign rst_b = sel ? r : 1'b1;

    reg_scoreboard_if #(.NREGS(32), .CNT_W(2), .NRET(2)) ia ();
    reg_scoreboard_if #(.NREGS(32), .CNT_W(2), .NRET(2)) ib ();

    assign ia.flush = fl;      assign ib.flush = fl;
    assign ia.id_valid = v;    assign ib.id_valid = v;
    assign ia.id_rs1 = rs1;    assign ib.id_rs1 = rs1;
    assign ia.id_en_rs1 = e1;  assign ib.id_en_rs1 = e1;
    assign ia.id_rs2 = rs2;    assign ib.id_rs2 = rs2;
    assign ia.id_en_rs2 = e2;  assign ib.id_en_rs2 = e2;
    assign ia.id_rd = rd;      assign ib.id_rd = rd;
    assign ia.id_en_rd = erd;  assign ib.id_en_rd = erd;
    assign ia.ex_ready = exr;  assign ib.ex_ready = exr;
    assign ia.ret_valid = rv;  assign ib.ret_valid = rv;
    assign ia.ret_rd = rrd;    assign ib.ret_rd = rrd;

    reg_scoreboard #(.NREGS(32), .CNT_W(2), .NRET(2), .CHECK_WAW(1), .WB_BYPASS(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    reg_scoreboard #(.NREGS(32), .CNT_W(2), .NRET(2), .CHECK_WAW(0), .WB_BYPASS(0))
        dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

    assign o_stall = sel ? ib.id_stall : ia.id_stall;
    assign o_issue = sel ? ib.issue : ia.issue;
    assign o_busy  = sel ? ib.busy_vec : ia.busy_vec;
    assign o_infl  = sel ? ib.inflight : ia.inflight;
    assign o_err   = sel ? ib.err : ia.err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        string t;
        t = tq.pop_front();
        chk({t, "_busy"}, o_busy, bq.pop_front());
        chk({t, "_inflight"}, 32'(o_infl), 32'(nq.pop_front()));
        chk({t, "_err"}, 32'(o_err), 32'(eq.pop_front()));
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, and queue the state
    // expected after the coming edge; it is checked at the start of the next step.
    task automatic step(input string tag, input logic rs, input logic f, input logic vv,
                        input logic [4:0] s1, input logic en1, input logic [4:0] s2, input logic en2,
                        input logic [4:0] d, input logic end_, input logic x,
                        input logic [1:0] rvv, input logic [4:0] d0, input logic [4:0] d1,
                        input logic xs, input logic xi,
                        input logic [31:0] xb, input logic [6:0] xn, input logic xe);
        @(negedge clk);
        if (tq.size() != 0) pop_chk();
        r = rs; fl = f; v = vv; rs1 = s1; e1 = en1; rs2 = s2; e2 = en2;
        rd = d; erd = end_; exr = x; rv = rvv; rrd = {d1, d0};
        #1;
        chk({tag, "_stall"}, 32'(o_stall), 32'(xs));
        chk({tag, "_issue"}, 32'(o_issue), 32'(xi));
        tq.push_back(tag);
        bq.push_back(xb);
        nq.push_back(xn);
        eq.push_back(xe);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        //    tag          rs f v  rs1 e1 rs2 e2 rd e  x  rv    r0 r1 st is busy          n  err
        step("a_iss5",     0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 2'b00, 0, 0, 0, 1, 32'h20,      1, 0);
        step("a_raw5",     0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 32'h20,      1, 0);
        step("a_byp5",     0, 0, 1, 0, 0, 5, 1, 0, 0, 1, 2'b01, 5, 0, 0, 1, 32'h0,       0, 0);
        step("a_iss8",     0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 2'b00, 0, 0, 0, 1, 32'h100,     1, 0);
        step("a_waw8",     0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 2'b00, 0, 0, 1, 0, 32'h100,     1, 0);
        step("a_wawbyp",   0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 2'b10, 0, 8, 0, 1, 32'h100,     1, 0);
        step("a_ret8",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0, 0, 32'h0,       0, 0);
        step("a_iss3",     0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 2'b00, 0, 0, 0, 1, 32'h8,       1, 0);
        step("a_iss4",     0, 0, 1, 0, 0, 0, 0, 4, 1, 1, 2'b00, 0, 0, 0, 1, 32'h18,      2, 0);
        step("a_flush",    0, 1, 1, 0, 0, 0, 0,10, 1, 1, 2'b01, 3, 0, 1, 0, 32'h0,       0, 0);
        step("a_zero",     0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 1, 32'h0,       0, 0);
        step("a_ret0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 32'h0,       0, 0);
        step("a_uf9",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 32'h0,       0, 1);
        step("a_errhold",  0, 0, 1, 9, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 32'h0,       0, 1);
        step("a_iss2",     0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 2'b00, 0, 0, 0, 1, 32'h4,       1, 1);
        step("a_rst",      1, 0, 1, 2, 1, 0, 0,11, 1, 1, 2'b01, 2, 0, 0, 1, 32'h0,       0, 0);
        step("a_post",     0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 32'h0,       0, 0);
        @(negedge clk);
        pop_chk();
        sel = 1'b1;
        step("b_iss5",     0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 2'b00, 0, 0, 0, 1, 32'h20,      1, 0);
        step("b_nobyp",    0, 0, 1, 0, 0, 5, 1, 0, 0, 1, 2'b01, 5, 0, 1, 0, 32'h0,       0, 0);
        step("b_clr",      0, 0, 1, 0, 0, 5, 1, 0, 0, 1, 2'b00, 0, 0, 0, 1, 32'h0,       0, 0);
        step("b_s1",       0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0, 1, 32'h80,      1, 0);
        step("b_s2",       0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0, 1, 32'h80,      2, 0);
        step("b_s3",       0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0, 1, 32'h80,      3, 0);
        step("b_sat",      0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 2'b00, 0, 0, 1, 0, 32'h80,      3, 0);
        step("b_satret",   0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 2'b01, 7, 0, 0, 1, 32'h80,      3, 0);
        step("b_i6a",      0, 0, 1, 0, 0, 0, 0, 6, 1, 1, 2'b00, 0, 0, 0, 1, 32'hC0,      4, 0);
        step("b_i6b",      0, 0, 1, 0, 0, 0, 0, 6, 1, 1, 2'b00, 0, 0, 0, 1, 32'hC0,      5, 0);
        step("b_dual",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 6, 6, 0, 0, 32'h80,      3, 0);
        step("b_uf",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h80,      3, 1);
        step("b_flush",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,       0, 1);
        step("b_flushv",   0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 1, 0, 32'h0,       0, 1);
        @(negedge clk);
        pop_chk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
